// File: rtl/ro_freq_counter.sv
`timescale 1ns/1ps
// Ring-oscillator frequency counter: counts osc_in rising edges during a fixed
// gate window of clk cycles and reports the per-window edge count.
module ro_freq_counter #(
  parameter int unsigned CNT_WIDTH     = 24,
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 osc_in,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GATE_W-1:0]    GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]    GATE_ONE    = GATE_W'(1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("GATE_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_STOP,
    S_CAPTURE,
    S_DONE
  } state_e;

  // NOTE: no reset here -- osc_in is not running while disabled, so a reset
  // could never be applied; only differences of this counter are ever used.
  logic [CNT_WIDTH-1:0] osc_cnt_q;

  always_ff @(posedge osc_in) begin
    osc_cnt_q <= osc_cnt_q + CNT_ONE;
  end

  // Multi-bit sync is safe: the counter is only consumed while it is static.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [CNT_WIDTH-1:0] sync1_q;
  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [CNT_WIDTH-1:0] sync2_q;

  // NOTE: non-blocking assignments in every clocked block, so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    sync1_q <= osc_cnt_q;
    sync2_q <= sync1_q;
  end

  state_e                state_q,  state_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [GATE_W-1:0]     gate_q,   gate_d;
  logic [CNT_WIDTH-1:0]  snap_q,   snap_d;
  logic [CNT_WIDTH-1:0]  count_q,  count_d;
  logic                  ro_en_q,  ro_en_d;
  logic                  done_q,   done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      gate_q   <= '0;
      snap_q   <= '0;
      count_q  <= '0;
      ro_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      ro_en_q  <= ro_en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    snap_d   = snap_q;
    count_d  = count_q;
    ro_en_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARM;
          settle_d = '0;
        end
      end
      S_ARM: begin
        if (settle_q == SETTLE_LAST) begin
          snap_d  = sync2_q;
          gate_d  = '0;
          ro_en_d = 1'b1;
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      S_RUN: begin
        if (gate_q == GATE_LAST) begin
          settle_d = '0;
          state_d  = S_STOP;
        end else begin
          gate_d  = gate_q + GATE_ONE;
          ro_en_d = 1'b1;
        end
      end
      S_STOP: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      S_CAPTURE: begin
        // Modular difference stays correct across counter wrap.
        count_d = sync2_q - snap_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ro_en = ro_en_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
`timescale 1ns/1ps
// Bench for ro_freq_counter: behavioural ring-oscillator model, timing model of
// a measurement, and a per-cycle compare process plus literal checks.
module tb_ro_freq_counter;

  localparam int CW  = 10;
  localparam int G   = 100;
  localparam int S   = 8;
  localparam int LAT = 2 * S + G + 1;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          osc_in = 1'b0;
  logic          ro_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  ro_freq_counter #(
    .CNT_WIDTH    (CW),
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .osc_in(osc_in),
    .ro_en (ro_en),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  // Ring oscillator: toggles every half_ns while enabled, parked low otherwise.
  // The tick grid is offset 0.3 ns from the clk edges.
  realtime half_ns  = 1.25;
  bit      osc_dead = 1'b0;

  initial begin
    #0.3;
    forever begin
      if (ro_en && !osc_dead) osc_in = ~osc_in;
      else                    osc_in = 1'b0;
      #(half_ns);
    end
  end

  int unsigned edge_total = 0;
  initial forever begin
    @(posedge osc_in);
    edge_total++;
  end

  // Measurement model: a start accepted at edge k yields a result equal to the
  // oscillator edges seen since k, published at edge k+LAT.
  int unsigned   cyc = 0;
  bit            m_active = 1'b0;
  bit            m_seen_reset = 1'b0;
  int unsigned   m_k = 0;
  int unsigned   m_snap = 0;
  logic [CW-1:0] m_count = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_active     = 1'b0;
      m_count      = '0;
      m_seen_reset = 1'b1;
    end else begin
      if (m_active && (cyc - m_k) == LAT) m_count = CW'(edge_total - m_snap);
      if (m_active && (cyc - m_k) >= LAT + 1) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_k      = cyc;
        m_snap   = edge_total;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +-%0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge.
  int unsigned done_cnt  = 0;
  int unsigned ro_hi_cnt = 0;
  int unsigned done_cyc  = 0;

  initial forever begin
    int unsigned p;
    @(negedge clk);
    if (m_seen_reset) begin
      p = cyc - m_k;
      check("cmp_busy",  busy,  m_active);
      check("cmp_done",  done,  m_active && p == LAT);
      check("cmp_ro_en", ro_en, m_active && p >= S && p < S + G);
      check("cmp_count", count, m_count);
    end
    if (ro_en) ro_hi_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic measure(input int hold, input bit repulse, input bit done_poke,
                         input int exp_nom, input int tol);
    int unsigned k;
    @(posedge clk); #2;
    done_cnt  = 0;
    ro_hi_cnt = 0;
    start     = 1'b1;
    @(posedge clk); #2;
    k = cyc;
    repeat (hold - 1) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    if (repulse) begin
      repeat (S + 20) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    if (done_poke) begin
      repeat (LAT - (hold - 1)) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    repeat (LAT + 40) @(posedge clk);
    #2;
    check("done_pulses", done_cnt, 1);
    check("done_latency", done_cyc - k, LAT);
    check("ro_en_cycles", ro_hi_cnt, G);
    check_near("count", int'(count), exp_nom, tol);
    if (done_poke) check("start_in_done_ignored", busy, 1'b0);
  endtask

  initial begin
    int unsigned k;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset_ro_en", ro_en, 1'b0);
    check("reset_busy",  busy,  1'b0);
    check("reset_done",  done,  1'b0);
    check("reset_count", count, 0);

    // 400 MHz oscillator, single start pulse.
    half_ns = 1.25;
    measure(1, 1'b0, 1'b0, 400, 1);

    // Start held 4 cycles and re-pulsed during RUN: one measurement only.
    measure(4, 1'b1, 1'b0, 400, 1);

    // Start presented in the DONE cycle must not launch a new measurement.
    measure(1, 1'b0, 1'b1, 400, 1);

    // Back-to-back runs: the 10-bit counter must wrap inside one of them.
    for (int r = 0; r < 3; r++) measure(1, 1'b0, 1'b0, 400, 1);

    // Reset at RUN cycle 40.
    @(posedge clk); #2;
    done_cnt = 0;
    start    = 1'b1;
    @(posedge clk); #2;
    k     = cyc;
    start = 1'b0;
    repeat (S + 39) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    check("abort_ro_en", ro_en, 1'b0);
    check("abort_busy",  busy,  1'b0);
    check("abort_count", count, 0);
    check("abort_cycle", cyc - k, S + 40);
    repeat (LAT + 20) @(posedge clk);
    #2 check("abort_no_done", done_cnt, 0);
    measure(1, 1'b0, 1'b0, 400, 1);

    // 100 MHz then 200 MHz; count holds 100 until the second capture.
    half_ns = 5.0;
    measure(1, 1'b0, 1'b0, 100, 1);
    half_ns = 2.5;
    measure(1, 1'b0, 1'b0, 200, 1);

    // Dead oscillator.
    osc_dead = 1'b1;
    measure(1, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
